// File: rtl/lbuf_pingpong_sched.sv
// -----------------------------------------------------------------------------
// lbuf_pingpong_sched
//
// Purpose:
//   Schedules a two-bank (ping-pong) image linebuffer between the pixel
//   capture write path and the PS DMA. Picks the bank each line is written
//   into, counts the 32-bit words of each line, raises a per-line interrupt
//   naming the ready bank, frees banks on the DMA-done handshake, and drops
//   lines while both banks are still owned by DMA.
//
// Optional feature macro:
//   LBUF_SCHED_STATS_EN  when defined, o_drop_count counts dropped lines in
//                        the current frame (saturating, cleared at frame
//                        start). When undefined, o_drop_count is tied to 0.
//
// Ports:
//   pclk          in   pixel clock, the only clock
//   reset_n       in   synchronous, active-low reset
//   i_enable      in   sampled only in IDLE; low keeps the block idle
//   i_vsync       in   rising edge = frame start
//   i_vde         in   video data enable (high during the active line)
//   i_wr_we       in   capture BRAM write strobe, one per 32-bit word
//   i_dma_done    in   1-cycle pulse: DMA finished reading bank i_dma_bank
//   i_dma_bank    in   bank released by i_dma_done
//   o_bank_sel    out  linebuffer address MSB for the capture path
//   o_line_irq    out  1-cycle pulse: a line is complete in o_line_bank
//   o_line_bank   out  bank holding the completed line
//   o_line_words  out  word count of the completed line
//   o_line_idx    out  index of the line being captured in the frame
//   o_frame_irq   out  1-cycle pulse: LINES lines handled
//   o_overrun     out  1-cycle pulse: a line was dropped
//   o_bank_full   out  per-bank "owned by DMA" flags
//   o_drop_count  out  dropped lines this frame
// -----------------------------------------------------------------------------
module lbuf_pingpong_sched #(
    parameter int LINES  = 480,
    parameter int WORD_W = 10,
    parameter int LINE_W = 10
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_vsync,
    input  logic              i_vde,
    input  logic              i_wr_we,
    input  logic              i_dma_done,
    input  logic              i_dma_bank,
    output logic              o_bank_sel,
    output logic              o_line_irq,
    output logic              o_line_bank,
    output logic [WORD_W-1:0] o_line_words,
    output logic [LINE_W-1:0] o_line_idx,
    output logic              o_frame_irq,
    output logic              o_overrun,
    output logic [1:0]        o_bank_full,
    output logic [15:0]       o_drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        ACTIVE,
        DROP
    } state_t;

    // State registers
    state_t              r_state;
    logic                r_vde_q;
    logic                r_vsync_q;
    logic                r_wr_bank;
    logic [WORD_W-1:0]   r_word_cnt;
    logic [1:0]          r_bank_full;
    logic                r_line_bank;
    logic [WORD_W-1:0]   r_line_words;
    logic [LINE_W-1:0]   r_line_idx;
    logic                r_line_irq;
    logic                r_frame_irq;
    logic                r_overrun;

    // Next-state values
    state_t              w_state_nxt;
    logic                w_wr_bank_nxt;
    logic [WORD_W-1:0]   w_word_cnt_nxt;
    logic [1:0]          w_bank_full_nxt;
    logic                w_line_bank_nxt;
    logic [WORD_W-1:0]   w_line_words_nxt;
    logic [LINE_W-1:0]   w_line_idx_nxt;
    logic                w_line_irq_nxt;
    logic                w_frame_irq_nxt;
    logic                w_overrun_nxt;

    // Edge detects and helpers
    logic                w_ls;
    logic                w_le;
    logic                w_fs;
    logic                w_frame_start;
    logic [1:0]          w_dma_clr;
    logic [1:0]          w_full_eff;
    logic [WORD_W-1:0]   w_word_inc;
    logic                w_last_line;

    assign w_ls = i_vde & ~r_vde_q;
    assign w_le = ~i_vde & r_vde_q;
    assign w_fs = i_vsync & ~r_vsync_q;

    // In IDLE a frame start is only honoured when enabled; in any other
    // state it aborts the current frame and restarts it.
    assign w_frame_start = w_fs & (i_enable | (r_state != IDLE));

    // DMA release is applied before the line-start check so that a bank
    // freed in the ls cycle can accept that very line.
    assign w_dma_clr  = i_dma_done ? (2'b01 << i_dma_bank) : 2'b00;
    assign w_full_eff = r_bank_full & ~w_dma_clr;

    // Saturating word increment: a line longer than the counter range
    // reports all-ones instead of wrapping to a small value.
    assign w_word_inc  = (r_word_cnt == '1) ? r_word_cnt : r_word_cnt + WORD_W'(1);
    assign w_last_line = (r_line_idx == LINE_W'(LINES - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt      = r_state;
        w_wr_bank_nxt    = r_wr_bank;
        w_word_cnt_nxt   = r_word_cnt;
        w_bank_full_nxt  = w_full_eff;
        w_line_bank_nxt  = r_line_bank;
        w_line_words_nxt = r_line_words;
        w_line_idx_nxt   = r_line_idx;
        w_line_irq_nxt   = 1'b0;
        w_frame_irq_nxt  = 1'b0;
        w_overrun_nxt    = 1'b0;

        if (w_frame_start) begin
            // A partial line is discarded; bank ownership is kept.
            w_state_nxt    = WAIT_LINE;
            w_line_idx_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                WAIT_LINE: begin
                    if (w_ls) begin
                        if (!w_full_eff[r_wr_bank]) begin
                            w_state_nxt    = ACTIVE;
                            w_word_cnt_nxt = i_wr_we ? WORD_W'(1) : '0;
                        end else begin
                            w_state_nxt   = DROP;
                            w_overrun_nxt = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_le) begin
                        w_bank_full_nxt[r_wr_bank] = 1'b1;
                        w_line_bank_nxt  = r_wr_bank;
                        w_wr_bank_nxt    = ~r_wr_bank;
                        w_line_idx_nxt   = r_line_idx + LINE_W'(1);
                        w_line_words_nxt = i_wr_we ? w_word_inc : r_word_cnt;
                        w_line_irq_nxt   = 1'b1;
                        w_frame_irq_nxt  = w_last_line;
                        w_state_nxt      = w_last_line ? IDLE : WAIT_LINE;
                    end else if (i_wr_we) begin
                        w_word_cnt_nxt = w_word_inc;
                    end
                end
                DROP: begin
                    if (w_le) begin
                        w_line_idx_nxt  = r_line_idx + LINE_W'(1);
                        w_frame_irq_nxt = w_last_line;
                        w_state_nxt     = w_last_line ? IDLE : WAIT_LINE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_vde_q      <= 1'b0;
            r_vsync_q    <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_word_cnt   <= '0;
            r_bank_full  <= 2'b00;
            r_line_bank  <= 1'b0;
            r_line_words <= '0;
            r_line_idx   <= '0;
            r_line_irq   <= 1'b0;
            r_frame_irq  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vde_q      <= i_vde;
            r_vsync_q    <= i_vsync;
            r_wr_bank    <= w_wr_bank_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_bank_full  <= w_bank_full_nxt;
            r_line_bank  <= w_line_bank_nxt;
            r_line_words <= w_line_words_nxt;
            r_line_idx   <= w_line_idx_nxt;
            r_line_irq   <= w_line_irq_nxt;
            r_frame_irq  <= w_frame_irq_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

`ifdef LBUF_SCHED_STATS_EN
    logic [15:0] r_drop_count;
    logic        w_drop_inc;

    assign w_drop_inc = (r_state == WAIT_LINE) & ~w_frame_start & w_ls & w_full_eff[r_wr_bank];

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_frame_start) begin
            r_drop_count <= '0;
        end else if (w_drop_inc && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`else
    assign o_drop_count = '0;
`endif

    assign o_bank_sel   = r_wr_bank;
    assign o_line_irq   = r_line_irq;
    assign o_line_bank  = r_line_bank;
    assign o_line_words = r_line_words;
    assign o_line_idx   = r_line_idx;
    assign o_frame_irq  = r_frame_irq;
    assign o_overrun    = r_overrun;
    assign o_bank_full  = r_bank_full;

endmodule

// File: tb/tb_lbuf_pingpong_sched.sv
// -----------------------------------------------------------------------------
// tb_lbuf_pingpong_sched
//
// Self-checking bench for lbuf_pingpong_sched (built with LINES=4 so a whole
// frame fits in a short run). A table of short-line vectors covers the
// accept / drop / DMA-release corner cases; hand-written sequences cover full
// 160-word lines, frame end, mid-line frame abort, reset in ACTIVE and word
// counter saturation. Expected drop counts depend on LBUF_SCHED_STATS_EN.
// -----------------------------------------------------------------------------
module tb_lbuf_pingpong_sched;

    localparam int LINES  = 4;
    localparam int WORD_W = 10;
    localparam int LINE_W = 10;

    logic              pclk;
    logic              reset_n;
    logic              i_enable;
    logic              i_vsync;
    logic              i_vde;
    logic              i_wr_we;
    logic              i_dma_done;
    logic              i_dma_bank;
    logic              o_bank_sel;
    logic              o_line_irq;
    logic              o_line_bank;
    logic [WORD_W-1:0] o_line_words;
    logic [LINE_W-1:0] o_line_idx;
    logic              o_frame_irq;
    logic              o_overrun;
    logic [1:0]        o_bank_full;
    logic [15:0]       o_drop_count;

    lbuf_pingpong_sched #(
        .LINES  (LINES),
        .WORD_W (WORD_W),
        .LINE_W (LINE_W)
    ) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .i_enable     (i_enable),
        .i_vsync      (i_vsync),
        .i_vde        (i_vde),
        .i_wr_we      (i_wr_we),
        .i_dma_done   (i_dma_done),
        .i_dma_bank   (i_dma_bank),
        .o_bank_sel   (o_bank_sel),
        .o_line_irq   (o_line_irq),
        .o_line_bank  (o_line_bank),
        .o_line_words (o_line_words),
        .o_line_idx   (o_line_idx),
        .o_frame_irq  (o_frame_irq),
        .o_overrun    (o_overrun),
        .o_bank_full  (o_bank_full),
        .o_drop_count (o_drop_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // {irq, line_bank, line_words, line_idx, frame_irq, overrun, bank_full, bank_sel, drop_count}
    wire [42:0] obs = {o_line_irq, o_line_bank, o_line_words, o_line_idx, o_frame_irq,
                       o_overrun, o_bank_full, o_bank_sel, o_drop_count};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        int rst, en, vs, vde, we, dd, db;
        int irq, lb, lw, li, fi, ov, bf, bs, drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string tag,
                                input int rst, input int en, input int vs, input int vde,
                                input int we, input int dd, input int db,
                                input int irq, input int lb, input int lw, input int li,
                                input int fi, input int ov, input int bf, input int bs,
                                input int drop);
        vec_t v;
        v.tag = tag;
        v.rst = rst; v.en = en; v.vs = vs; v.vde = vde; v.we = we; v.dd = dd; v.db = db;
        v.irq = irq; v.lb = lb; v.lw = lw; v.li = li; v.fi = fi; v.ov = ov;
        v.bf = bf; v.bs = bs; v.drop = drop;
        return v;
    endfunction

    function automatic logic [15:0] exp_drop(input int d);
`ifdef LBUF_SCHED_STATS_EN
        return d[15:0];
`else
        return (d == d) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs, then step one clock edge and settle 1 time unit past it.
    task automatic drive(input logic rst, input logic en, input logic vs, input logic vde,
                         input logic we, input logic dd, input logic db);
        reset_n    = rst;
        i_enable   = en;
        i_vsync    = vs;
        i_vde      = vde;
        i_wr_we    = we;
        i_dma_done = dd;
        i_dma_bank = db;
        @(posedge pclk);
        #1;
    endtask

    // One accepted line of n words (wr_we on every active cycle), the le
    // cycle, then a gap cycle that optionally releases the bank via DMA.
    task automatic capture_line(input string tag, input int n, input int dma_after,
                                input int eb, input int ew, input int ei, input int ef,
                                input int efull);
        int gap_full;
        drive(1, 1, 0, 1, 1, 0, 0);
        check({tag, "_bsel"}, 64'(o_bank_sel), 64'(eb[0]));
        for (int i = 1; i < n; i++) drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        check({tag, "_le"},
              64'({o_line_irq, o_line_bank, o_line_words, o_line_idx, o_frame_irq,
                   o_overrun, o_bank_full, o_bank_sel}),
              64'({1'b1, eb[0], ew[9:0], ei[9:0], ef[0], 1'b0, efull[1:0], ~eb[0]}));
        drive(1, 1, 0, 0, 0, dma_after[0], eb[0]);
        gap_full = (dma_after != 0) ? (efull & ~(1 << eb)) : efull;
        check({tag, "_gap"}, 64'({o_line_irq, o_frame_irq, o_bank_full}),
              64'({1'b0, 1'b0, gap_full[1:0]}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; i_enable = 1'b0; i_vsync = 1'b0; i_vde = 1'b0;
        i_wr_we = 1'b0; i_dma_done = 1'b0; i_dma_bank = 1'b0;

        //            tag            rst en vs vde we dd db  irq lb lw li fi ov bf bs drop
        vecs.push_back(mk("rst0",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rst1",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("fs",          1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("l0_ls",       1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("l0_w",        1, 1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("l0_le",       1, 1, 0, 0, 0, 0, 0,   1, 0, 2, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("l0_gap",      1, 1, 0, 0, 0, 0, 0,   0, 0, 2, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("l1_ls",       1, 1, 0, 1, 1, 0, 0,   0, 0, 2, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("l1_w",        1, 1, 0, 1, 0, 0, 0,   0, 0, 2, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("l1_le_we",    1, 1, 0, 0, 1, 0, 0,   1, 1, 2, 2, 0, 0, 3, 0, 0));
        vecs.push_back(mk("l1_gap",      1, 1, 0, 0, 0, 0, 0,   0, 1, 2, 2, 0, 0, 3, 0, 0));
        vecs.push_back(mk("l2_ls_drop",  1, 1, 0, 1, 1, 0, 0,   0, 1, 2, 2, 0, 1, 3, 0, 1));
        vecs.push_back(mk("l2_w",        1, 1, 0, 1, 1, 0, 0,   0, 1, 2, 2, 0, 0, 3, 0, 1));
        vecs.push_back(mk("l2_le",       1, 1, 0, 0, 0, 0, 0,   0, 1, 2, 3, 0, 0, 3, 0, 1));
        vecs.push_back(mk("l3_ls_dma",   1, 1, 0, 1, 1, 1, 0,   0, 1, 2, 3, 0, 0, 2, 0, 1));
        vecs.push_back(mk("l3_w",        1, 1, 0, 1, 1, 0, 0,   0, 1, 2, 3, 0, 0, 2, 0, 1));
        vecs.push_back(mk("l3_le_frame", 1, 1, 0, 0, 0, 0, 0,   1, 0, 2, 4, 1, 0, 3, 1, 1));
        vecs.push_back(mk("idle",        1, 1, 0, 0, 0, 0, 0,   0, 0, 2, 4, 0, 0, 3, 1, 1));
        vecs.push_back(mk("idle_ls",     1, 1, 0, 1, 1, 0, 0,   0, 0, 2, 4, 0, 0, 3, 1, 1));
        vecs.push_back(mk("idle_le",     1, 1, 0, 0, 0, 0, 0,   0, 0, 2, 4, 0, 0, 3, 1, 1));
        vecs.push_back(mk("dma0",        1, 1, 0, 0, 0, 1, 0,   0, 0, 2, 4, 0, 0, 2, 1, 1));
        vecs.push_back(mk("dma0_again",  1, 1, 0, 0, 0, 1, 0,   0, 0, 2, 4, 0, 0, 2, 1, 1));
        vecs.push_back(mk("dma1",        1, 1, 0, 0, 0, 1, 1,   0, 0, 2, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk("dis_fs",      1, 0, 1, 0, 0, 0, 0,   0, 0, 2, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk("dis_ls",      1, 0, 0, 1, 1, 0, 0,   0, 0, 2, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk("dis_le",      1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 4, 0, 0, 0, 1, 1));

        foreach (vecs[k]) begin
            drive(vecs[k].rst[0], vecs[k].en[0], vecs[k].vs[0], vecs[k].vde[0],
                  vecs[k].we[0], vecs[k].dd[0], vecs[k].db[0]);
            check(vecs[k].tag, 64'(obs),
                  64'({vecs[k].irq[0], vecs[k].lb[0], vecs[k].lw[9:0], vecs[k].li[9:0],
                       vecs[k].fi[0], vecs[k].ov[0], vecs[k].bf[1:0], vecs[k].bs[0],
                       exp_drop(vecs[k].drop)}));
        end

        // Full frame of four 160-word lines with DMA release after each irq.
        drive(0, 0, 0, 0, 0, 0, 0);
        check("reset_b", 64'(obs), 64'(0));
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        check("frame_start", 64'({o_line_idx, o_drop_count}), 64'(0));
        for (int k = 0; k < LINES; k++) begin
            capture_line($sformatf("f%0d", k), 160, 1, k % 2, 160, k + 1,
                         (k == LINES - 1) ? 1 : 0, 1 << (k % 2));
        end
        drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        check("post_frame_ls", 64'({o_line_irq, o_line_idx, o_bank_full, o_bank_sel}),
              64'({1'b0, 10'd4, 2'b00, 1'b0}));

        // Frame start in the middle of an active line aborts it.
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 1, 1, 1, 0, 0);
        check("abort_fs", 64'({o_line_irq, o_line_idx, o_bank_full, o_bank_sel}),
              64'({1'b0, 10'd0, 2'b00, 1'b0}));
        drive(1, 1, 1, 0, 0, 0, 0);
        check("abort_le", 64'({o_line_irq, o_line_idx, o_bank_full}), 64'(0));
        drive(1, 1, 0, 0, 0, 0, 0);
        capture_line("after_abort", 8, 0, 0, 8, 1, 0, 2'b01);

        // Reset while ACTIVE in bank 1 with bank 0 owned by DMA.
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 1, 1, 0, 0);
        check("reset_active", 64'(obs), 64'(0));
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        capture_line("post_rst", 4, 1, 0, 4, 1, 0, 2'b01);

        // Word counter saturates at all-ones.
        capture_line("sat", 1030, 0, 1, 1023, 2, 0, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
